sync_fifo_v2: RTL and testbench
===============================

# sync_fifo_v2

Parametrised single-clock FIFO that succeeds the existing 8×8 synchronous FIFO. It adds arbitrary (non-power-of-two) depth, a selectable first-word-fall-through read mode, programmable almost-full/almost-empty thresholds, an exported fill level, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, as a drop-in buffer wherever the older FIFO is used.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries (≥2, any integer)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full asserts when count ≥ this value (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserts when count ≤ this value (0..DEPTH-1)

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- write_en  in  1  push request
- write_data  in  WIDTH  push data
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- read_en  in  1  pop request (in FWFT mode: acknowledge of the displayed word)
- read_data  out  WIDTH  read word
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  CW  current number of stored words
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty
- clear_err  in  1  synchronous clear of overflow/underflow

## Operation
- Accepted write: do_write = write_en && !full. Accepted read: do_read = read_en && !empty. Both flags are evaluated on pre-edge state.
- When full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write is accepted in the same cycle.
- Pointers:
  - write_ptr and read_ptr are $clog2(DEPTH) bits wide.
  - Each pointer increments on its accepted operation.
  - Each pointer wraps explicitly from DEPTH-1 to 0; modulo-2^n wrap is not allowed.
- count:
  - +1 on write only; −1 on read only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- full, empty, almost_full and almost_empty are decoded combinationally from registered count.
- Memory is written only on do_write. Storage contents are not reset.
- Read modes:
  - FWFT=0: on do_read, read_data <= mem[read_ptr] at the edge. Otherwise read_data holds its value.
  - FWFT=1: read_data = mem[read_ptr] combinationally. It is valid whenever empty=0 and undefined while empty=1. do_read advances to the next word.
- Error flags:
  - overflow sets on write_en && full; underflow sets on read_en && empty.
  - Both are sticky until clear_err.
  - If clear_err coincides with a new error in the same cycle, the set wins.
- Reset (async assert):
  - Pointers and count go to 0.
  - empty=1, almost_empty=1, full=0, almost_full=0.
  - overflow=0, underflow=0, read_data=0.
  - Reset mid-transfer discards all stored words; the first write after deassertion lands at entry 0.

## Timing
- Write → empty deasserts: 1 cycle (visible after the accepting edge).
- FWFT=0:
  - A read accepted at edge N presents data after edge N.
  - The earliest read of a first word written at edge N is accepted at edge N+1, so data appears after N+1.
- FWFT=1: a word written at edge N into an empty FIFO appears on read_data after edge N, in the same cycle that empty falls.
- Simultaneous accepted read and write:
  - count, full and empty are unchanged.
  - Both pointers advance.
  - Legal at any fill level between 1 and DEPTH-1.
- Full → read only: full deasserts after 1 edge.
- Error flags register 1 cycle after the offending request.
- Throughput: one write and one read per cycle sustained; no bubbles in either mode.

## Test plan
- Reset/flags: DEPTH=16. Hold reset low, then release. Required: count=0, empty=1, almost_empty=1, full=0, almost_full=0, read_data=0, overflow=0, underflow=0.
- Fill/drain, FWFT=0, DEPTH=5 (non-power-of-two):
  - Write 0x11..0x15 on 5 consecutive cycles. Required: full=1, count=5, almost_full=1 (threshold 3).
  - Write 0x99. Required: rejected, overflow=1.
  - Read 5 times. Required: read_data = 0x11..0x15 in order, each visible one edge after its accepted read.
- Wrap-around, DEPTH=5:
  - Run 12 cycles of write+read together at count=2 with an incrementing pattern. Required: output order is preserved across pointer wrap; count stays at 2 throughout.
- FWFT=1:
  - Write 0xA5 into an empty FIFO. Required: read_data=0xA5 and empty=0 in the following cycle, with no read issued.
  - Pulse read_en. Required: empty=1 and count=0.
- Errors and clear:
  - Read while empty. Required: underflow=1.
  - Pulse clear_err. Required: underflow returns to 0.
  - Assert clear_err and read_en together while empty. Required: underflow stays 1.
- Mid-operation reset:
  - Write 3 words, then assert reset asynchronously between edges. Required: count=0 and empty=1 immediately, without waiting for an edge.
  - Write 0x3C after deassertion. Required: 0x3C is the first word read.

Source files
------------

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2 -- parameterised single-clock FIFO.
//
// Arbitrary depth (explicit pointer wrap at DEPTH-1), registered or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, exported fill level and sticky overflow/underflow flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        async active-low reset
//   write_en     push request          write_data  push word
//   read_en      pop request / FWFT acknowledge
//   read_data    read word (registered when FWFT=0, combinational when FWFT=1)
//   full/empty, almost_full/almost_empty  decoded from registered count
//   count        stored words (0..DEPTH)
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
//   clear_err    synchronous clear of both sticky flags
module sync_fifo_v2 #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] write_data,
  output logic             full,
  output logic             almost_full,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             empty,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T     = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_T     = CW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_unf;
  logic             w_do_write, w_do_read;
  logic [AW-1:0]    w_wptr_nxt, w_rptr_nxt;

  // Flags come from registered count only, so accept decisions use
  // pre-edge state: a full FIFO rejects a write even alongside a read.
  assign full         = (r_count == CNT_FULL);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_T);
  assign almost_empty = (r_count <= AE_T);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  assign w_do_write = write_en && !full;
  assign w_do_read  = read_en && !empty;

  // Explicit wrap so non-power-of-two depths never index past the array.
  assign w_wptr_nxt = (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_write) r_wptr <= w_wptr_nxt;
      if (w_do_read)  r_rptr <= w_rptr_nxt;
      case ({w_do_write, w_do_read})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[r_wptr] <= write_data;
  end

  // Sticky errors; a new error in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (write_en && full) r_ovf <= 1'b1;
      else if (clear_err)   r_ovf <= 1'b0;
      if (read_en && empty) r_unf <= 1'b1;
      else if (clear_err)   r_unf <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; forced to 0 while empty so the
      // output is deterministic after reset.
      assign read_data = empty ? '0 : r_mem[r_rptr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_rdata <= '0;
        else if (w_do_read) r_rdata <= r_mem[r_rptr];
      end
      assign read_data = r_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Directed bench for sync_fifo_v2: three instances (DEPTH=16 registered,
// DEPTH=5 registered with almost_full threshold 3, DEPTH=4 FWFT).
module tb_sync_fifo_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: DEPTH=16, FWFT=0
  logic       a_we, a_re, a_clr;
  logic [7:0] a_wd, a_rd;
  logic       a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
  logic [4:0] a_cnt;
  // instance B: DEPTH=5, FWFT=0, AFULL_THRESH=3
  logic       b_we, b_re, b_clr;
  logic [7:0] b_wd, b_rd;
  logic       b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
  logic [2:0] b_cnt;
  // instance C: DEPTH=4, FWFT=1
  logic       c_we, c_re, c_clr;
  logic [7:0] c_wd, c_rd;
  logic       c_full, c_af, c_empty, c_ae, c_ovf, c_unf;
  logic [2:0] c_cnt;

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .reset(rst_n), .write_en(a_we), .write_data(a_wd),
    .full(a_full), .almost_full(a_af), .read_en(a_re), .read_data(a_rd),
    .empty(a_empty), .almost_empty(a_ae), .count(a_cnt),
    .overflow(a_ovf), .underflow(a_unf), .clear_err(a_clr));

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(2)) u_b (
    .clk(clk), .reset(rst_n), .write_en(b_we), .write_data(b_wd),
    .full(b_full), .almost_full(b_af), .read_en(b_re), .read_data(b_rd),
    .empty(b_empty), .almost_empty(b_ae), .count(b_cnt),
    .overflow(b_ovf), .underflow(b_unf), .clear_err(b_clr));

  sync_fifo_v2 #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
    .clk(clk), .reset(rst_n), .write_en(c_we), .write_data(c_wd),
    .full(c_full), .almost_full(c_af), .read_en(c_re), .read_data(c_rd),
    .empty(c_empty), .almost_empty(c_ae), .count(c_cnt),
    .overflow(c_ovf), .underflow(c_unf), .clear_err(c_clr));

  // Advance to 1 time unit after the next rising edge; inputs changed
  // here take effect at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we = 0; a_re = 0; a_clr = 0; a_wd = 8'h00;
    b_we = 0; b_re = 0; b_clr = 0; b_wd = 8'h00;
    c_we = 0; c_re = 0; c_clr = 0; c_wd = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++; if (a_cnt !== 5'd0) begin errors++; $display("FAIL rst_in_count: got %0d want 0", a_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_cnt !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", a_cnt); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", a_empty); end
    checks++; if (a_ae !== 1'b1) begin errors++; $display("FAIL rst_aempty: got %b want 1", a_ae); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", a_full); end
    checks++; if (a_af !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b want 0", a_af); end
    checks++; if (a_rd !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %0h want 0", a_rd); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", a_ovf); end
    checks++; if (a_unf !== 1'b0) begin errors++; $display("FAIL rst_unf: got %b want 0", a_unf); end
    checks++; if (c_rd !== 8'h00) begin errors++; $display("FAIL rst_fwft_rdata: got %0h want 0", c_rd); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    logic       exp_ae, exp_af;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b_we = 1; b_wd = 8'h11 + 8'(i);
      tick();
      exp_ae = ((i + 1) <= 2);
      exp_af = ((i + 1) >= 3);
      checks++; if (b_cnt !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, b_cnt, i + 1); end
      checks++; if (b_ae !== exp_ae) begin errors++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, b_ae, exp_ae); end
      checks++; if (b_af !== exp_af) begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, b_af, exp_af); end
    end
    b_we = 0;
    checks++; if (b_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", b_full); end
    // rejected write while full
    b_we = 1; b_wd = 8'h99;
    tick();
    b_we = 0;
    checks++; if (b_cnt !== 3'd5) begin errors++; $display("FAIL ovf_count: got %0d want 5", b_cnt); end
    checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", b_ovf); end
    for (int i = 0; i < 5; i++) begin
      b_re = 1;
      tick();
      exp_d = 8'h11 + 8'(i);
      checks++; if (b_rd !== exp_d) begin errors++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, b_rd, exp_d); end
      if (i == 0) begin
        checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL drain_full_drop: got %b want 0", b_full); end
      end
    end
    b_re = 0;
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", b_empty); end
    // read_data holds after the last read
    tick();
    checks++; if (b_rd !== 8'h15) begin errors++; $display("FAIL drain_hold: got %0h want 15", b_rd); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    // pointers currently at 0 after fill/drain; run through several wraps
    b_we = 1; b_wd = 8'h20; tick();
    b_wd = 8'h21; tick();
    checks++; if (b_cnt !== 3'd2) begin errors++; $display("FAIL wrap_pre_count: got %0d want 2", b_cnt); end
    for (int i = 0; i < 12; i++) begin
      b_we = 1; b_re = 1; b_wd = 8'h22 + 8'(i);
      tick();
      exp_d = 8'h20 + 8'(i);
      checks++; if (b_rd !== exp_d) begin errors++; $display("FAIL wrap_data[%0d]: got %0h want %0h", i, b_rd, exp_d); end
      checks++; if (b_cnt !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 2", i, b_cnt); end
    end
    b_we = 0; b_re = 0;
  endtask

  task automatic test_fwft();
    do_reset();
    c_we = 1; c_wd = 8'hA5;
    tick();
    c_we = 0;
    checks++; if (c_rd !== 8'hA5) begin errors++; $display("FAIL fwft_data: got %0h want a5", c_rd); end
    checks++; if (c_empty !== 1'b0) begin errors++; $display("FAIL fwft_empty_fall: got %b want 0", c_empty); end
    c_re = 1;
    tick();
    c_re = 0;
    checks++; if (c_empty !== 1'b1) begin errors++; $display("FAIL fwft_empty_rise: got %b want 1", c_empty); end
    checks++; if (c_cnt !== 3'd0) begin errors++; $display("FAIL fwft_count: got %0d want 0", c_cnt); end
    // back-to-back: two writes then consecutive acknowledges
    c_we = 1; c_wd = 8'hB1; tick();
    c_wd = 8'hB2; tick();
    c_we = 0;
    checks++; if (c_rd !== 8'hB1) begin errors++; $display("FAIL fwft_b2b0: got %0h want b1", c_rd); end
    c_re = 1; tick();
    checks++; if (c_rd !== 8'hB2) begin errors++; $display("FAIL fwft_b2b1: got %0h want b2", c_rd); end
    tick();
    c_re = 0;
    checks++; if (c_empty !== 1'b1) begin errors++; $display("FAIL fwft_b2b_empty: got %b want 1", c_empty); end
  endtask

  task automatic test_errors();
    do_reset();
    checks++; if (b_ovf !== 1'b0) begin errors++; $display("FAIL err_ovf_reset: got %b want 0", b_ovf); end
    b_re = 1; tick(); b_re = 0;
    checks++; if (b_unf !== 1'b1) begin errors++; $display("FAIL err_unf_set: got %b want 1", b_unf); end
    tick();
    checks++; if (b_unf !== 1'b1) begin errors++; $display("FAIL err_unf_sticky: got %b want 1", b_unf); end
    b_clr = 1; tick(); b_clr = 0;
    checks++; if (b_unf !== 1'b0) begin errors++; $display("FAIL err_unf_clear: got %b want 0", b_unf); end
    b_clr = 1; b_re = 1; tick(); b_clr = 0; b_re = 0;
    checks++; if (b_unf !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", b_unf); end
    checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL err_count: got %0d want 0", b_cnt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      b_we = 1; b_wd = 8'h01 + 8'(i);
      tick();
    end
    b_we = 0;
    checks++; if (b_cnt !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d want 3", b_cnt); end
    // assert reset between edges and look before the next edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b_cnt !== 3'd0) begin errors++; $display("FAIL mid_async_count: got %0d want 0", b_cnt); end
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL mid_async_empty: got %b want 1", b_empty); end
    tick();
    rst_n = 1'b1;
    tick();
    b_we = 1; b_wd = 8'h3C; tick(); b_we = 0;
    checks++; if (b_cnt !== 3'd1) begin errors++; $display("FAIL mid_post_count: got %0d want 1", b_cnt); end
    b_re = 1; tick(); b_re = 0;
    checks++; if (b_rd !== 8'h3C) begin errors++; $display("FAIL mid_first_word: got %0h want 3c", b_rd); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_fwft();
    test_errors();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
